// File: rtl/load_store_queue.sv
// load_store_queue
//   In-order load/store queue sitting between issue and the memory controller.
//   Entries are held in program order; each computes its effective address as
//   base + offset when it reaches the front. Operands wake up by snooping the
//   ALU broadcast and this block's own load broadcast. Stores go to memory only
//   once the ROB has committed them; load data is sign/zero-extended before it
//   is broadcast. A misprediction flush drops every entry that is not a
//   committed store.
//
//   Optional build macro: LSQ_MMIO_GATE_EN
//     When defined, a load whose effective address is >= MMIO_BASE waits until
//     it is at the ROB head before dispatching (no speculative I/O reads).
//
// Ports
//   clk_in, rst_in (sync, active high), rdy_in (global enable)
//   issue_*   : push one load/store with operand values or producer tags
//   alu_*     : ALU result broadcast used for operand wake-up
//   commit_*  : ROB commit of a store; rob_head_tag for the MMIO gate
//   flush     : misprediction flush
//   mem_*     : single outstanding memory request and its completion
//   cdb_*     : load result broadcast (one-cycle pulse)
//   full      : issue must stall (one entry of slack for registered issue)
//
// FSM states
//   state | meaning
//   IDLE  | no request outstanding; dispatch front entry when it is ready
//   WAIT  | request outstanding; waiting for mem_done
module load_store_queue #(
  parameter int                   LSQ_WIDTH = 4,
  parameter int                   ROB_WIDTH = 4,
  parameter int                   REG_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0] MMIO_BASE = 32'h30000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_signal,
  input  logic                 issue_wr,
  input  logic [1:0]           issue_len,
  input  logic                 issue_signed,
  input  logic [REG_WIDTH-1:0] issue_base,
  input  logic [ROB_WIDTH-1:0] issue_tag_base,
  input  logic                 issue_valid_base,
  input  logic [REG_WIDTH-1:0] issue_offset,
  input  logic [REG_WIDTH-1:0] issue_data,
  input  logic [ROB_WIDTH-1:0] issue_tag_data,
  input  logic                 issue_valid_data,
  input  logic [ROB_WIDTH-1:0] issue_tag_rd,
  input  logic                 alu_signal,
  input  logic [REG_WIDTH-1:0] alu_value,
  input  logic [ROB_WIDTH-1:0] alu_tag,
  input  logic                 commit_signal,
  input  logic [ROB_WIDTH-1:0] commit_tag,
  input  logic [ROB_WIDTH-1:0] rob_head_tag,
  input  logic                 flush,
  output logic                 mem_signal,
  output logic                 mem_wr,
  output logic [1:0]           mem_len,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0] mem_dout,
  input  logic [REG_WIDTH-1:0] mem_din,
  input  logic                 mem_done,
  output logic                 cdb_signal,
  output logic [REG_WIDTH-1:0] cdb_value,
  output logic [ROB_WIDTH-1:0] cdb_tag,
  output logic                 full
);

  localparam int LSQ_SIZE = 2 ** LSQ_WIDTH;
  localparam logic [LSQ_WIDTH:0]   QCAP    = (LSQ_WIDTH + 1)'(LSQ_SIZE);
  localparam logic [LSQ_WIDTH:0]   QCAP_M1 = (LSQ_WIDTH + 1)'(LSQ_SIZE - 1);
  localparam logic [LSQ_WIDTH-1:0] PTR_ONE = 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;

  logic [LSQ_SIZE-1:0]  busy, is_wr, is_signed, vbase, vdata, committed;
  logic [1:0]           len_q      [LSQ_SIZE];
  logic [REG_WIDTH-1:0] base_q     [LSQ_SIZE];
  logic [REG_WIDTH-1:0] offset_q   [LSQ_SIZE];
  logic [REG_WIDTH-1:0] data_q     [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] tag_base_q [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] tag_data_q [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] tag_rd_q   [LSQ_SIZE];

  logic [LSQ_WIDTH-1:0] front, rear;
  logic [LSQ_WIDTH:0]   count;
  logic                 drop_q;   // in-flight load was flushed; swallow its completion

  logic [LSQ_SIZE-1:0]  commit_hit, comm_eff;
  logic [LSQ_WIDTH:0]   n_comm;
  logic [REG_WIDTH-1:0] ea;
  logic                 load_ok, front_ready, inflight_dropped;
  logic                 dispatch, pop, cdb_fire, push;
  logic [REG_WIDTH-1:0] new_base, new_data;
  logic                 new_vbase, new_vdata;

  function automatic logic [REG_WIDTH-1:0] extend(input logic [REG_WIDTH-1:0] d,
                                                  input logic [1:0] len,
                                                  input logic sgn);
    case (len)
      2'd0:    return {{(REG_WIDTH-8){sgn & d[7]}}, d[7:0]};
      2'd1:    return {{(REG_WIDTH-16){sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign full = (count >= QCAP_M1);
  assign ea   = base_q[front] + offset_q[front];

`ifdef LSQ_MMIO_GATE_EN
  assign load_ok = (ea < MMIO_BASE) || (tag_rd_q[front] == rob_head_tag);
`else
  logic unused_mmio;
  assign unused_mmio = ^{rob_head_tag, MMIO_BASE};
  assign load_ok     = 1'b1;
`endif

  // Commit is folded in before flush so a same-cycle commit survives the flush.
  always_comb begin
    n_comm = '0;
    for (int i = 0; i < LSQ_SIZE; i++) begin
      commit_hit[i] = commit_signal && busy[i] && is_wr[i] && (tag_rd_q[i] == commit_tag);
      comm_eff[i]   = committed[i] | commit_hit[i];
      n_comm        = n_comm + (LSQ_WIDTH + 1)'(busy[i] & comm_eff[i]);
    end
  end

  assign front_ready = busy[front] && vbase[front] &&
                       (is_wr[front] ? (vdata[front] && committed[front]) : load_ok);
  assign inflight_dropped = drop_q || (flush && !comm_eff[front]);

  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    pop      = 1'b0;
    cdb_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (front_ready && !flush) begin
          dispatch = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_d = IDLE;
          if (!inflight_dropped) begin
            pop      = 1'b1;
            cdb_fire = !is_wr[front];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = issue_signal && !flush && ((count != QCAP) || pop);

  // Same-cycle bypass of a broadcast into an operand arriving as a tag.
  always_comb begin
    new_base  = issue_base;
    new_vbase = issue_valid_base;
    if (!issue_valid_base) begin
      if (alu_signal && alu_tag == issue_tag_base) begin
        new_base  = alu_value;
        new_vbase = 1'b1;
      end else if (cdb_signal && cdb_tag == issue_tag_base) begin
        new_base  = cdb_value;
        new_vbase = 1'b1;
      end
    end
    new_data  = issue_data;
    new_vdata = issue_valid_data;
    if (!issue_valid_data) begin
      if (alu_signal && alu_tag == issue_tag_data) begin
        new_data  = alu_value;
        new_vdata = 1'b1;
      end else if (cdb_signal && cdb_tag == issue_tag_data) begin
        new_data  = cdb_value;
        new_vdata = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      front      <= '0;
      rear       <= '0;
      count      <= '0;
      drop_q     <= 1'b0;
      busy       <= '0;
      committed  <= '0;
      is_wr      <= '0;
      is_signed  <= '0;
      vbase      <= '0;
      vdata      <= '0;
      mem_signal <= 1'b0;
      mem_wr     <= 1'b0;
      mem_len    <= '0;
      mem_addr   <= '0;
      mem_dout   <= '0;
      cdb_signal <= 1'b0;
      cdb_value  <= '0;
      cdb_tag    <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (busy[i]) begin
          if (!vbase[i]) begin
            if (alu_signal && alu_tag == tag_base_q[i]) begin
              base_q[i] <= alu_value;
              vbase[i]  <= 1'b1;
            end else if (cdb_signal && cdb_tag == tag_base_q[i]) begin
              base_q[i] <= cdb_value;
              vbase[i]  <= 1'b1;
            end
          end
          if (!vdata[i]) begin
            if (alu_signal && alu_tag == tag_data_q[i]) begin
              data_q[i] <= alu_value;
              vdata[i]  <= 1'b1;
            end else if (cdb_signal && cdb_tag == tag_data_q[i]) begin
              data_q[i] <= cdb_value;
              vdata[i]  <= 1'b1;
            end
          end
          if (commit_hit[i]) committed[i] <= 1'b1;
          if (flush && !comm_eff[i]) busy[i] <= 1'b0;
        end
      end

      if (pop) begin
        busy[front]      <= 1'b0;
        committed[front] <= 1'b0;
        front            <= front + PTR_ONE;
      end

      // A push into a full queue reuses the slot being popped, so it goes last.
      if (push) begin
        busy[rear]       <= 1'b1;
        committed[rear]  <= 1'b0;
        is_wr[rear]      <= issue_wr;
        is_signed[rear]  <= issue_signed;
        len_q[rear]      <= issue_len;
        base_q[rear]     <= new_base;
        vbase[rear]      <= new_vbase;
        tag_base_q[rear] <= issue_tag_base;
        offset_q[rear]   <= issue_offset;
        data_q[rear]     <= new_data;
        vdata[rear]      <= new_vdata;
        tag_data_q[rear] <= issue_tag_data;
        tag_rd_q[rear]   <= issue_tag_rd;
      end

      // Committed stores always form a prefix starting at front.
      if (flush) begin
        rear  <= front + n_comm[LSQ_WIDTH-1:0];
        count <= n_comm - {{LSQ_WIDTH{1'b0}}, pop};
      end else begin
        if (push) rear <= rear + PTR_ONE;
        count <= count + {{LSQ_WIDTH{1'b0}}, push} - {{LSQ_WIDTH{1'b0}}, pop};
      end

      if (state_q == WAIT && mem_done) drop_q <= 1'b0;
      else if (state_q == WAIT && flush && !comm_eff[front]) drop_q <= 1'b1;

      if (dispatch) begin
        mem_signal <= 1'b1;
        mem_wr     <= is_wr[front];
        mem_len    <= len_q[front];
        mem_addr   <= ea;
        mem_dout   <= data_q[front];
      end else if (state_q == WAIT && mem_done) begin
        mem_signal <= 1'b0;
      end

      cdb_signal <= cdb_fire;
      if (cdb_fire) begin
        cdb_value <= extend(mem_din, len_q[front], is_signed[front]);
        cdb_tag   <= tag_rd_q[front];
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_signal, issue_wr, issue_signed, issue_valid_base, issue_valid_data;
  logic [1:0]  issue_len;
  logic [31:0] issue_base, issue_offset, issue_data;
  logic [3:0]  issue_tag_base, issue_tag_data, issue_tag_rd;
  logic        alu_signal;
  logic [31:0] alu_value;
  logic [3:0]  alu_tag;
  logic        commit_signal;
  logic [3:0]  commit_tag, rob_head_tag;
  logic        flush;
  logic        mem_signal, mem_wr, mem_done;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        cdb_signal;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_tag;
  logic        full;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  load_store_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_signal(issue_signal), .issue_wr(issue_wr), .issue_len(issue_len),
    .issue_signed(issue_signed), .issue_base(issue_base), .issue_tag_base(issue_tag_base),
    .issue_valid_base(issue_valid_base), .issue_offset(issue_offset),
    .issue_data(issue_data), .issue_tag_data(issue_tag_data),
    .issue_valid_data(issue_valid_data), .issue_tag_rd(issue_tag_rd),
    .alu_signal(alu_signal), .alu_value(alu_value), .alu_tag(alu_tag),
    .commit_signal(commit_signal), .commit_tag(commit_tag), .rob_head_tag(rob_head_tag),
    .flush(flush),
    .mem_signal(mem_signal), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_done(mem_done),
    .cdb_signal(cdb_signal), .cdb_value(cdb_value), .cdb_tag(cdb_tag), .full(full)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_ld(input logic [31:0] base, input logic [31:0] off,
                          input logic [1:0] len, input logic sgn, input logic [3:0] tag);
    issue_signal = 1'b1; issue_wr = 1'b0; issue_len = len; issue_signed = sgn;
    issue_base = base; issue_valid_base = 1'b1; issue_tag_base = 4'd0;
    issue_offset = off; issue_data = 32'd0; issue_valid_data = 1'b1;
    issue_tag_data = 4'd0; issue_tag_rd = tag;
    tick();
    issue_signal = 1'b0;
  endtask

  task automatic issue_st(input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] data, input logic vdata,
                          input logic [3:0] tdata, input logic [3:0] tag);
    issue_signal = 1'b1; issue_wr = 1'b1; issue_len = 2'd2; issue_signed = 1'b0;
    issue_base = base; issue_valid_base = 1'b1; issue_tag_base = 4'd0;
    issue_offset = off; issue_data = data; issue_valid_data = vdata;
    issue_tag_data = tdata; issue_tag_rd = tag;
    tick();
    issue_signal = 1'b0;
  endtask

  // Issue a load into an empty, idle queue and run it to completion.
  task automatic do_load(input string nm, input logic [31:0] base, input logic [31:0] off,
                         input logic [1:0] len, input logic sgn, input logic [3:0] tag,
                         input logic [31:0] din, input logic [31:0] exp_addr,
                         input logic [31:0] exp_val);
    issue_ld(base, off, len, sgn, tag);
    chk({nm, ".no_req_yet"}, 32'(mem_signal), 32'd0);
    tick();
    chk({nm, ".mem_signal"}, 32'(mem_signal), 32'd1);
    chk({nm, ".mem_addr"}, mem_addr, exp_addr);
    chk({nm, ".mem_wr"}, 32'(mem_wr), 32'd0);
    chk({nm, ".mem_len"}, 32'(mem_len), 32'(len));
    mem_din = din; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk({nm, ".cdb_signal"}, 32'(cdb_signal), 32'd1);
    chk({nm, ".cdb_value"}, cdb_value, exp_val);
    chk({nm, ".cdb_tag"}, 32'(cdb_tag), 32'(tag));
    chk({nm, ".mem_released"}, 32'(mem_signal), 32'd0);
    tick();
    chk({nm, ".cdb_pulse"}, 32'(cdb_signal), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_signal = 0; issue_wr = 0; issue_len = 0; issue_signed = 0;
    issue_base = 0; issue_tag_base = 0; issue_valid_base = 0; issue_offset = 0;
    issue_data = 0; issue_tag_data = 0; issue_valid_data = 0; issue_tag_rd = 0;
    alu_signal = 0; alu_value = 0; alu_tag = 0;
    commit_signal = 0; commit_tag = 0; rob_head_tag = 0; flush = 0;
    mem_din = 0; mem_done = 0;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst.mem_signal", 32'(mem_signal), 32'd0);
    chk("rst.cdb_signal", 32'(cdb_signal), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.cdb_value", cdb_value, 32'd0);

    // Plain loads and extension.
    do_load("ld_word", 32'h100, 32'h4, 2'd2, 1'b0, 4'd5, 32'hDEADBEEF, 32'h104, 32'hDEADBEEF);
    do_load("lb_s",    32'h0,  32'h20, 2'd0, 1'b1, 4'd6, 32'h00000080, 32'h20, 32'hFFFFFF80);
    do_load("lb_u",    32'h0,  32'h20, 2'd0, 1'b0, 4'd7, 32'h00000080, 32'h20, 32'h00000080);
    do_load("lh_s",    32'h10, 32'hFFFFFFFE, 2'd1, 1'b1, 4'd8, 32'h12348001, 32'hE, 32'hFFFF8001);

    // Store with data woken by the ALU, held back until commit.
    issue_st(32'h200, 32'h8, 32'h0, 1'b0, 4'd3, 4'd9);
    alu_signal = 1'b1; alu_tag = 4'd3; alu_value = 32'h55;
    tick();
    alu_signal = 1'b0;
    chk("st.wait_commit0", 32'(mem_signal), 32'd0);
    tick(); tick();
    chk("st.wait_commit1", 32'(mem_signal), 32'd0);
    commit_signal = 1'b1; commit_tag = 4'd9;
    tick();
    commit_signal = 1'b0;
    chk("st.commit_edge", 32'(mem_signal), 32'd0);
    tick();
    chk("st.mem_signal", 32'(mem_signal), 32'd1);
    chk("st.mem_wr", 32'(mem_wr), 32'd1);
    chk("st.mem_dout", mem_dout, 32'h55);
    chk("st.mem_addr", mem_addr, 32'h208);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("st.released", 32'(mem_signal), 32'd0);
    chk("st.no_cdb", 32'(cdb_signal), 32'd0);

    // Fill to LSQ_SIZE-1 without completions; pointers wrap through index 0.
    for (int i = 0; i < 15; i++) begin
      issue_ld(32'h1000, 32'(i * 4), 2'd2, 1'b0, 4'(i));
      if (i == 13) chk("fill.not_full_14", 32'(full), 32'd0);
    end
    chk("fill.full_15", 32'(full), 32'd1);
    for (int i = 0; i < 15; i++) begin
      chk("drain.mem_signal", 32'(mem_signal), 32'd1);
      chk("drain.mem_addr", mem_addr, 32'h1000 + 32'(i * 4));
      mem_din = 32'(i) + 32'hA0; mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("drain.cdb_tag", 32'(cdb_tag), 32'(i));
      chk("drain.cdb_value", cdb_value, 32'(i) + 32'hA0);
      if (i == 0) chk("drain.full_cleared", 32'(full), 32'd0);
      tick();
    end
    chk("drain.empty", 32'(mem_signal), 32'd0);

    // rdy_in low: an issue must not be accepted.
    rdy_in = 1'b0;
    issue_ld(32'h900, 32'h0, 2'd2, 1'b0, 4'd8);
    tick();
    chk("rdy.hold", 32'(mem_signal), 32'd0);
    rdy_in = 1'b1;
    tick(); tick();
    chk("rdy.nothing_queued", 32'(mem_signal), 32'd0);

    // Flush with a committed store in flight and two younger loads.
    issue_st(32'h300, 32'h0, 32'hAA, 1'b1, 4'd0, 4'd1);
    issue_ld(32'h310, 32'h0, 2'd2, 1'b0, 4'd2);
    issue_ld(32'h320, 32'h0, 2'd2, 1'b0, 4'd3);
    commit_signal = 1'b1; commit_tag = 4'd1;
    tick();
    commit_signal = 1'b0;
    tick();
    chk("fl.st_req", 32'(mem_signal), 32'd1);
    chk("fl.st_addr", mem_addr, 32'h300);
    chk("fl.st_dout", mem_dout, 32'hAA);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.st_kept", 32'(mem_signal), 32'd1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("fl.st_done", 32'(mem_signal), 32'd0);
    chk("fl.st_no_cdb", 32'(cdb_signal), 32'd0);
    tick(); tick();
    chk("fl.loads_dropped", 32'(mem_signal), 32'd0);
    do_load("fl.after", 32'h400, 32'h0, 2'd2, 1'b0, 4'd4, 32'h1234, 32'h400, 32'h1234);

    // Flush while an uncommitted load is in flight.
    issue_ld(32'h500, 32'h0, 2'd2, 1'b0, 4'd5);
    tick();
    chk("fll.req", 32'(mem_signal), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fll.still_wait", 32'(mem_signal), 32'd1);
    mem_din = 32'h77; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("fll.no_cdb", 32'(cdb_signal), 32'd0);
    chk("fll.released", 32'(mem_signal), 32'd0);
    tick();
    chk("fll.no_redispatch", 32'(mem_signal), 32'd0);
    do_load("fll.after", 32'h600, 32'h8, 2'd2, 1'b0, 4'd6, 32'h99, 32'h608, 32'h99);

`ifdef LSQ_MMIO_GATE_EN
    rob_head_tag = 4'd0;
    issue_ld(32'h30000, 32'h0, 2'd2, 1'b0, 4'd7);
    tick(); tick();
    chk("mmio.gated", 32'(mem_signal), 32'd0);
    rob_head_tag = 4'd7;
    tick();
    chk("mmio.dispatch", 32'(mem_signal), 32'd1);
    chk("mmio.addr", mem_addr, 32'h30000);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("mmio.cdb_tag", 32'(cdb_tag), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- Parametrised successor to the single-port load/store buffer.
- Holds loads and stores in program order between issue and the memory controller.
- Computes the effective address in-block as base + offset.
- Snoops two result buses (ALU and its own load broadcast) to wake operands.
- Sends stores to memory only after ROB commit; sign/zero-extends load data.
- Supports misprediction flush that keeps committed stores.

Parameters:
- LSQ_WIDTH, 4, log2 of queue depth; LSQ_SIZE = 2**LSQ_WIDTH.
- ROB_WIDTH, 4, ROB tag width.
- REG_WIDTH, 32, data and address width.
- MMIO_BASE, 32'h30000, first address treated as I/O (used by the optional feature only).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; when low, all state holds.
- issue_signal  in  1  push one entry.
- issue_wr  in  1  1 = store, 0 = load.
- issue_len  in  2  0 = byte, 1 = half, 2 = word.
- issue_signed  in  1  load sign-extend (LB/LH).
- issue_base  in  REG_WIDTH  base operand value.
- issue_tag_base  in  ROB_WIDTH  tag of base producer.
- issue_valid_base  in  1  base operand is a value, not a tag.
- issue_offset  in  REG_WIDTH  sign-extended immediate.
- issue_data  in  REG_WIDTH  store data value.
- issue_tag_data  in  ROB_WIDTH  tag of store-data producer.
- issue_valid_data  in  1  store data is a value.
- issue_tag_rd  in  ROB_WIDTH  ROB entry of this instruction.
- alu_signal  in  1  ALU broadcast valid.
- alu_value  in  REG_WIDTH  ALU broadcast value.
- alu_tag  in  ROB_WIDTH  ALU broadcast tag.
- commit_signal  in  1  ROB commits the store whose tag is commit_tag.
- commit_tag  in  ROB_WIDTH  committed tag.
- rob_head_tag  in  ROB_WIDTH  current ROB head.
- flush  in  1  misprediction flush.
- mem_signal  out  1  request valid; held until mem_done.
- mem_wr  out  1  1 = write.
- mem_len  out  2  access length.
- mem_addr  out  REG_WIDTH  access address.
- mem_dout  out  REG_WIDTH  store data.
- mem_din  in  REG_WIDTH  raw load data, low-aligned.
- mem_done  in  1  one-cycle completion pulse.
- cdb_signal  out  1  load result valid, one-cycle pulse.
- cdb_value  out  REG_WIDTH  extended load result.
- cdb_tag  out  ROB_WIDTH  ROB tag of the load.
- full  out  1  issue stage must stall.

Behaviour:
- Reset: front, rear and count = 0; every entry invalid; mem_signal, cdb_signal = 0; mem_wr = 0; mem_len, mem_addr, mem_dout, cdb_value, cdb_tag = 0; state = IDLE.
- count is LSQ_WIDTH+1 bits, so all LSQ_SIZE entries are usable. full = (count >= LSQ_SIZE-1), combinational; this gives one cycle of slack for registered issue.
- Issue writes the entry at rear; rear wraps modulo LSQ_SIZE. Push and pop in the same cycle leave count unchanged.
- Operand bypass at issue: if an operand arrives invalid and its tag matches an alu_signal or cdb_signal broadcast in the same cycle, the broadcast value is captured and the operand is marked valid.
- Wake-up: every busy entry compares its base and data tags against both broadcast buses each cycle. On a match it captures the value and sets valid. If both buses match, the ALU bus wins. The effective address is base + offset, computed when dispatching; wrap modulo 2^REG_WIDTH.
- Commit: on commit_signal, the busy store with tag_rd == commit_tag sets its committed bit.
- FSM:
  - IDLE -> WAIT when the front entry is busy, its base is valid, and either (store with data valid and committed) or (load). On this transition drive mem_* and set mem_signal = 1.
  - WAIT -> IDLE on mem_done: clear mem_signal the next edge, free the front entry, advance front.
  - For a load, also pulse cdb_signal with cdb_tag = tag_rd. cdb_value is mem_din extended per len and signed: byte sign-extends from bit 7, half from bit 15, word passes through.
  - Strictly in order; one outstanding request.
- Flush:
  - All entries without the committed bit are dropped. rear = front + number of committed stores; count updates to match.
  - A committed store already in flight completes normally.
  - An uncommitted load in flight: FSM stays in WAIT until mem_done, then returns to IDLE with no cdb pulse and no front advance (that entry is already dropped).
  - If flush and issue occur in the same cycle, flush wins and the issue is ignored.
  - If flush and commit occur in the same cycle, commit is applied first.
- rdy_in low: no state change; outputs hold.

Optional Feature:
- Macro: LSQ_MMIO_GATE_EN.
- Defined: a load whose effective address >= MMIO_BASE dispatches only when tag_rd == rob_head_tag. This prevents speculative I/O reads.
- Undefined: loads dispatch as soon as their operands are ready; MMIO_BASE is unused.

Test Plan:
- Load, base 0x100 valid, offset 4, len = 2 -> mem_addr 0x104, mem_wr = 0; mem_din 0xDEADBEEF -> cdb pulse value 0xDEADBEEF with the issued tag.
- Load byte, signed = 1, mem_din 0x00000080 -> cdb_value 0xFFFFFF80; same access with signed = 0 -> 0x00000080.
- Store with data tag 3 invalid; alu broadcast tag 3, value 0x55 -> still no mem_signal until commit_signal with its tag; then mem_dout 0x55, mem_wr = 1.
- Fill with LSQ_SIZE-1 issues and no mem_done -> full = 1; one completion -> full = 0; rear wraps to index 0 correctly.
- Committed store followed by two loads, flush -> store completes; loads never reach memory; count = 0 after mem_done.
- With LSQ_MMIO_GATE_EN, load to 0x30000 with rob_head_tag mismatched -> no mem_signal; head matches -> dispatch the next cycle.
